apb_cmd_arbiter: RTL
====================

Name: apb_cmd_arbiter

Overview:
- Shares the single APB bridge command port ({rw, addr, data} plus cmd_vld/cmd_rdy) between NUM_REQ requesters using round-robin arbitration.
- Sequences each granted command into the bridge and drives the bridge `transfer` enable.
- Tracks one outstanding read at a time and routes the returned read data to the requester that issued it.
- Sits between the requester masters and the bridge command input, in the a_pclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, data field width.
- ADDR_WIDTH, 12, address field width.
- CMD_WIDTH, DATA_WIDTH+ADDR_WIDTH+1, command width. Bit [CMD_WIDTH-1] is rw (1 = write).
- MAX_BURST, 4, maximum commands accepted per locked grant (1..15).

Ports:
- a_pclk  in  1  command-side clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands; requester k occupies bits [k*CMD_WIDTH +: CMD_WIDTH].
- req_vld  in  NUM_REQ  per-requester command valid.
- req_lock  in  NUM_REQ  per-requester burst lock request.
- req_rdy  out  NUM_REQ  per-requester command accepted.
- cmd_out  out  CMD_WIDTH  command to bridge.
- cmd_vld  out  1  command valid to bridge.
- cmd_rdy  in  1  bridge ready.
- transfer  out  1  bridge transfer enable.
- rd_done  in  1  one-cycle pulse: bridge read data valid.
- rd_data_in  in  DATA_WIDTH  bridge read data (apb_rdata).
- rsp_vld  out  NUM_REQ  one-hot read-response valid.
- rsp_data  out  DATA_WIDTH  read-response data.
- grant_id  out  $clog2(NUM_REQ)  current grant owner.

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE.
  - grant_id, rsp_vld, rsp_data, transfer and burst_cnt are cleared to 0.
  - Round-robin pointer last_gnt is set to NUM_REQ-1, so requester 0 wins first.
  - cmd_vld and req_rdy are 0 because they are gated by state.
- FSM has three states: IDLE, GRANT, WAIT_RD. transfer is registered and equals 1 whenever next state != IDLE.
- IDLE:
  - If any req_vld is high, select the first set bit searching from last_gnt+1 upward with wrap-around.
  - Register it into grant_id, clear burst_cnt, go to GRANT.
  - Grant latency: 1 cycle from req_vld to cmd_vld.
- GRANT (datapath is combinational):
  - cmd_out = req_cmd[grant_id].
  - cmd_vld = req_vld[grant_id].
  - req_rdy[grant_id] = cmd_rdy. All other req_rdy bits are 0.
- Handshake occurs when cmd_vld && cmd_rdy; burst_cnt increments on it.
  - Read (rw=0): go to WAIT_RD.
  - Write with req_lock[grant_id]=1 and burst_cnt+1 < MAX_BURST: stay in GRANT.
  - Otherwise: set last_gnt = grant_id, go to IDLE.
- GRANT with req_vld[grant_id]=0 and req_lock[grant_id]=0: release (last_gnt = grant_id, go to IDLE). With lock held and vld low, the grant is held.
- WAIT_RD:
  - cmd_vld = 0.
  - On rd_done: rsp_data <= rd_data_in and rsp_vld <= onehot(grant_id), a registered one-cycle pulse.
  - Then return to GRANT if locked and burst_cnt < MAX_BURST; otherwise release to IDLE.
- rd_done in IDLE or GRANT is ignored and no rsp_vld is produced.
- A burst limit of MAX_BURST forces release, even if lock stays high.
- Reset asserted mid-command or mid-read: the FSM aborts immediately and no response pulse is issued.
- grant_id holds its last value in IDLE.

Optional Feature:
- Macro APB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest-index valid requester wins in IDLE. last_gnt is not updated. Lock and burst rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
1. After reset, all req_vld=0 → IDLE, transfer=0, req_rdy=0, rsp_vld=0. Then req_vld=4'b1010 → grant_id=1 on the next cycle, cmd_vld=1, cmd_out=req_cmd[1].
2. Round-robin: requesters 0..3 each issue one write continuously with cmd_rdy=1 → grants in order 0,1,2,3,0. Each grant is separated by one IDLE cycle.
3. Read routing: requester 2 issues read addr=0x008, and rd_done arrives 5 cycles later with rd_data_in=0x0000_0009 → rsp_vld=4'b0100 for exactly 1 cycle with rsp_data=0x9. No other grant occurs during WAIT_RD.
4. Lock burst: requester 0 holds req_lock=1 with 6 back-to-back writes, MAX_BURST=4, and requester 1 is valid → 4 writes accepted from 0, then grant_id=1.
5. Backpressure: cmd_rdy=0 for 3 cycles → cmd_out is stable, req_rdy[gnt]=0, no grant change. cmd_rdy=1 → single acceptance.
6. Reset during WAIT_RD: rstn low, then high → IDLE, rsp_vld stays 0, and a subsequent rd_done is ignored. With APB_ARB_FIXED_PRIO_EN, the repeated 4'b1111 requests → requester 0 always wins.

Source files
------------

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing one APB bridge command port between NUM_REQ requesters.
// Define APB_ARB_FIXED_PRIO_EN to use fixed lowest-index priority instead of round-robin.
module apb_cmd_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned CMD_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          a_pclk,
    input  logic                          rstn,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]  req_cmd,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic [CMD_WIDTH-1:0]          cmd_out,
    output logic                          cmd_vld,
    input  logic                          cmd_rdy,
    output logic                          transfer,
    input  logic                          rd_done,
    input  logic [DATA_WIDTH-1:0]         rd_data_in,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StGrant, StWaitRd} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        grant_id_q, grant_id_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  transfer_q, transfer_d;
`ifndef APB_ARB_FIXED_PRIO_EN
    logic [IdW-1:0]        last_gnt_q, last_gnt_d;
`endif

    logic [CMD_WIDTH-1:0]  sel_cmd;
    logic                  sel_vld;
    logic                  sel_lock;
    logic                  handshake;
    logic [3:0]            burst_nxt;
    logic [IdW-1:0]        pick;
    logic                  pick_found;

    assign sel_cmd   = req_cmd[int'(grant_id_q)*CMD_WIDTH +: CMD_WIDTH];
    assign sel_vld   = req_vld[grant_id_q];
    assign sel_lock  = req_lock[grant_id_q];
    assign handshake = (state_q == StGrant) && sel_vld && cmd_rdy;
    assign burst_nxt = burst_cnt_q + 4'd1;

    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
`ifdef APB_ARB_FIXED_PRIO_EN
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                pick       = IdW'(i);
                pick_found = 1'b1;
            end
        end
`else
        // Search upward from the requester after the last owner, wrapping around.
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            if (!pick_found && req_vld[(int'(last_gnt_q) + i) % int'(NUM_REQ)]) begin
                pick       = IdW'((int'(last_gnt_q) + i) % int'(NUM_REQ));
                pick_found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        rsp_vld_d   = '0;
        rsp_data_d  = rsp_data_q;
`ifndef APB_ARB_FIXED_PRIO_EN
        last_gnt_d  = last_gnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_id_d  = pick;
                    burst_cnt_d = '0;
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                if (handshake) begin
                    burst_cnt_d = burst_nxt;
                    if (!sel_cmd[CMD_WIDTH-1]) begin
                        state_d = StWaitRd;
                    end else if (!(sel_lock && (32'(burst_nxt) < MAX_BURST))) begin
                        state_d = StIdle;
`ifndef APB_ARB_FIXED_PRIO_EN
                        last_gnt_d = grant_id_q;
`endif
                    end
                end else if (!sel_vld && !sel_lock) begin
                    state_d = StIdle;
`ifndef APB_ARB_FIXED_PRIO_EN
                    last_gnt_d = grant_id_q;
`endif
                end
            end
            StWaitRd: begin
                if (rd_done) begin
                    rsp_data_d = rd_data_in;
                    rsp_vld_d  = NUM_REQ'(1) << grant_id_q;
                    if (sel_lock && (32'(burst_cnt_q) < MAX_BURST)) begin
                        state_d = StGrant;
                    end else begin
                        state_d = StIdle;
`ifndef APB_ARB_FIXED_PRIO_EN
                        last_gnt_d = grant_id_q;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        transfer_d = (state_d != StIdle);
    end

    always_ff @(posedge a_pclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
            rsp_vld_q   <= '0;
            rsp_data_q  <= '0;
            transfer_q  <= 1'b0;
`ifndef APB_ARB_FIXED_PRIO_EN
            last_gnt_q  <= IdW'(NUM_REQ - 1);
`endif
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_data_q  <= rsp_data_d;
            transfer_q  <= transfer_d;
`ifndef APB_ARB_FIXED_PRIO_EN
            last_gnt_q  <= last_gnt_d;
`endif
        end
    end

    always_comb begin
        req_rdy = '0;
        if (state_q == StGrant) begin
            req_rdy[grant_id_q] = cmd_rdy;
        end
    end

    assign cmd_out  = sel_cmd;
    assign cmd_vld  = (state_q == StGrant) && sel_vld;
    assign transfer = transfer_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign grant_id = grant_id_q;

endmodule
